// File: rtl/div_issue_ctrl_pkg.sv
// Shared constants for the divider issue controller: one-hot divide types,
// RV64M funct3 codes and the controller state encoding.
package div_issue_ctrl_pkg;

    localparam logic [7:0] DT_DIV   = 8'h80;
    localparam logic [7:0] DT_DIVU  = 8'h40;
    localparam logic [7:0] DT_DIVUW = 8'h20;
    localparam logic [7:0] DT_DIVW  = 8'h10;
    localparam logic [7:0] DT_REM   = 8'h08;
    localparam logic [7:0] DT_REMU  = 8'h04;
    localparam logic [7:0] DT_REMUW = 8'h02;
    localparam logic [7:0] DT_REMW  = 8'h01;

    localparam logic [2:0] F3_DIV  = 3'd4;
    localparam logic [2:0] F3_DIVU = 3'd5;
    localparam logic [2:0] F3_REM  = 3'd6;
    localparam logic [2:0] F3_REMU = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

endpackage

// File: rtl/div_issue_ctrl_type_dec.sv
// Combinational decode of {funct3, word} into the divider's one-hot type.
// Non-divide funct3 values decode to all zeros.
module div_type_dec
    import div_issue_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       word,
    output logic [7:0] div_type
);

    always_comb begin
        div_type = 8'h00;
        case (funct3)
            F3_DIV:  div_type = word ? DT_DIVW  : DT_DIV;
            F3_DIVU: div_type = word ? DT_DIVUW : DT_DIVU;
            F3_REM:  div_type = word ? DT_REMW  : DT_REM;
            F3_REMU: div_type = word ? DT_REMUW : DT_REMU;
            default: div_type = 8'h00;
        endcase
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Execute-stage front end for the iterative divider: accepts one op at a time,
// launches it, captures the result (including the zero-cycle exception path) and hands it to WB.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic             in_word,
    input  logic [XLEN-1:0]  in_src1,
    input  logic [XLEN-1:0]  in_src2,
    input  logic [TAG_W-1:0] in_rd,
    output logic             div_valid,
    output logic [7:0]       div_type,
    output logic [XLEN-1:0]  div_a,
    output logic [XLEN-1:0]  div_b,
    input  logic             div_stall,
    input  logic             div_ok,
    input  logic [XLEN-1:0]  div_out,
    output logic             div_rready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_rd,
    output logic             busy
);

    state_t            state_reg, state_next;
    logic [XLEN-1:0]   a_reg, a_next;
    logic [XLEN-1:0]   b_reg, b_next;
    logic [XLEN-1:0]   data_reg, data_next;
    logic [TAG_W-1:0]  rd_reg, rd_next;
    logic [7:0]        type_reg, type_next;
    logic [7:0]        dec_type;
    logic              take;

    div_type_dec u_dec (
        .funct3   (in_funct3),
        .word     (in_word),
        .div_type (dec_type)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            data_reg  <= '0;
            rd_reg    <= '0;
            type_reg  <= '0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            data_reg  <= data_next;
            rd_reg    <= rd_next;
            type_reg  <= type_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        data_next  = data_reg;
        rd_next    = rd_reg;
        type_next  = type_reg;
        in_ready   = 1'b0;
        take       = 1'b0;

        case (state_reg)
            ST_IDLE: in_ready = ~flush;
            ST_ISSUE: begin
                // A flushed real divide must still be drained; a flushed fast-path result is simply lost.
                if (flush) begin
                    state_next = div_stall ? ST_DRAIN : ST_IDLE;
                end else if (div_stall) begin
                    state_next = ST_WAIT;
                end else begin
                    data_next  = div_out;
                    state_next = ST_RESP;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_next = div_ok ? ST_IDLE : ST_DRAIN;
                end else if (div_ok) begin
                    data_next  = div_out;
                    state_next = ST_RESP;
                end
            end
            ST_DRAIN: begin
                if (div_ok) begin
                    state_next = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else if (out_ready) begin
                    state_next = ST_IDLE;
                    in_ready   = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Acceptance overrides the IDLE/handoff transition so back-to-back ops need no bubble.
        take = in_valid & in_ready;
        if (take) begin
            a_next    = in_src1;
            b_next    = in_src2;
            rd_next   = in_rd;
            type_next = dec_type;
            if (dec_type == 8'h00) begin
                data_next  = '0;
                state_next = ST_RESP;
            end else begin
                state_next = ST_ISSUE;
            end
        end
    end

    assign div_valid  = (state_reg == ST_ISSUE);
    assign div_rready = (state_reg == ST_WAIT) || (state_reg == ST_DRAIN);
    assign out_valid  = (state_reg == ST_RESP);
    assign busy       = (state_reg != ST_IDLE);
    assign div_type   = type_reg;
    assign div_a      = a_reg;
    assign div_b      = b_reg;
    assign out_data   = data_reg;
    assign out_rd     = rd_reg;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Scoreboard bench for div_issue_ctrl with a behavioural divider stub whose
// latency, fast-path flag and result come from hand-computed directed vectors.
module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_funct3 = 3'd0;
    logic        in_word = 1'b0;
    logic [63:0] in_src1 = '0;
    logic [63:0] in_src2 = '0;
    logic [4:0]  in_rd = '0;
    logic        div_valid;
    logic [7:0]  div_type;
    logic [63:0] div_a, div_b;
    logic        div_stall, div_ok;
    logic [63:0] div_out;
    logic        div_rready;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic        busy;

    div_issue_ctrl #(.XLEN(64), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3), .in_word(in_word),
        .in_src1(in_src1), .in_src2(in_src2), .in_rd(in_rd),
        .div_valid(div_valid), .div_type(div_type), .div_a(div_a), .div_b(div_b),
        .div_stall(div_stall), .div_ok(div_ok), .div_out(div_out), .div_rready(div_rready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Divider stub: combinational stall/fast result, countdown for real divides.
    logic        stub_fast = 1'b0;
    int          stub_lat = 1;
    logic [63:0] stub_result = '0;
    int          stub_cnt = 0;

    assign div_ok    = (stub_cnt == 1);
    assign div_stall = div_valid & ~stub_fast;
    assign div_out   = (stub_fast || div_ok) ? stub_result : 64'hDEAD_BEEF_DEAD_BEEF;

    always @(posedge clk) begin
        if (!rst_n)                       stub_cnt <= 0;
        else if (div_valid && div_stall)  stub_cnt <= stub_lat;
        else if (stub_cnt > 1)            stub_cnt <= stub_cnt - 1;
        else if (stub_cnt == 1 && div_rready) stub_cnt <= 0;
    end

    typedef struct { logic [63:0] data; logic [4:0] rd; int lat; int acc; } resp_t;
    typedef struct { logic [7:0] t; logic [63:0] a; logic [63:0] b; } launch_t;
    resp_t   out_q[$];
    launch_t launch_q[$];

    // Monitor: checks launches and responses against the queues.
    initial begin
        logic        prev_dv, prev_ov, prev_acc;
        logic [63:0] prev_data;
        logic [4:0]  prev_rd;
        resp_t       r;
        launch_t     l;
        prev_dv = 0; prev_ov = 0; prev_acc = 0; prev_data = '0; prev_rd = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_dv = 0; prev_ov = 0; prev_acc = 0;
            end else begin
                if (div_valid) begin
                    chk("div_valid_single_cycle", prev_dv, 1'b0);
                    chk("launch_expected", launch_q.size() != 0, 1'b1);
                    if (launch_q.size() != 0) begin
                        l = launch_q.pop_front();
                        chk("div_type", div_type, l.t);
                        chk("div_a", div_a, l.a);
                        chk("div_b", div_b, l.b);
                    end
                end
                if (out_valid) begin
                    if (!prev_ov || prev_acc) begin
                        chk("out_expected", out_q.size() != 0, 1'b1);
                        if (out_q.size() != 0)
                            chk("latency", cyc - out_q[0].acc, out_q[0].lat);
                    end else begin
                        chk("out_data_stable", out_data, prev_data);
                        chk("out_rd_stable", out_rd, prev_rd);
                    end
                    if (out_ready && out_q.size() != 0) begin
                        r = out_q.pop_front();
                        $display("resp rd=%0d data=%h", out_rd, out_data);
                        chk("out_data", out_data, r.data);
                        chk("out_rd", out_rd, r.rd);
                    end
                end
                prev_dv   = div_valid;
                prev_ov   = out_valid;
                prev_acc  = out_valid & out_ready;
                prev_data = out_data;
                prev_rd   = out_rd;
            end
        end
    end

    // Caller is aligned just after a posedge; returns just after the posedge following acceptance.
    task automatic issue(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd, input logic [7:0] t, input logic fast, input int lat,
                         input logic [63:0] res, input logic expect_out, output logic handoff);
        logic got;
        in_funct3 = f3; in_word = w; in_src1 = a; in_src2 = b; in_rd = rd;
        stub_fast = fast; stub_lat = lat; stub_result = res;
        in_valid = 1'b1;
        got = 1'b0;
        handoff = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                handoff = out_valid;
                $display("issue f3=%0d w=%0d a=%h b=%h rd=%0d", f3, w, a, b, rd);
                if (expect_out)
                    out_q.push_back('{data: res, rd: rd,
                                      lat: (t == 8'h00) ? 1 : (fast ? 2 : lat + 2), acc: cyc});
                if (t != 8'h00)
                    launch_q.push_back('{t: t, a: a, b: b});
            end
        end
        chk("accept_timeout", got, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (!busy && out_q.size() == 0) done = 1'b1;
        end
        chk("done_timeout", done, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ho;
        int   acc;
        logic ok_seen;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_div_valid", div_valid, 1'b0);
        chk("rst_div_rready", div_rready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_div_type", div_type, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors: f3, word, a, b, rd, type, fast, lat, result
        issue(3'd5, 1'b0, 64'd100, 64'd7, 5'd3, 8'h40, 1'b0, 5, 64'd14, 1'b1, ho); wait_done();
        issue(3'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd7, 8'h01, 1'b0, 4,
              64'hFFFF_FFFF_FFFF_FFFF, 1'b1, ho); wait_done();
        issue(3'd4, 1'b0, 64'd123, 64'd0, 5'd1, 8'h80, 1'b1, 1,
              64'hFFFF_FFFF_FFFF_FFFF, 1'b1, ho); wait_done();
        issue(3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 8'h80, 1'b1, 1,
              64'h8000_0000_0000_0000, 1'b1, ho); wait_done();
        issue(3'd7, 1'b0, 64'd100, 64'd7, 5'd10, 8'h04, 1'b0, 2, 64'd2, 1'b1, ho); wait_done();
        issue(3'd4, 1'b1, 64'd20, 64'hFFFF_FFFF_FFFF_FFFC, 5'd11, 8'h10, 1'b0, 6,
              64'hFFFF_FFFF_FFFF_FFFB, 1'b1, ho); wait_done();
        issue(3'd5, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h10, 5'd12, 8'h20, 1'b0, 1,
              64'h0000_0000_0FFF_FFFF, 1'b1, ho); wait_done();
        issue(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd3, 5'd13, 8'h08, 1'b0, 3,
              64'hFFFF_FFFF_FFFF_FFFF, 1'b1, ho); wait_done();
        issue(3'd7, 1'b1, 64'd17, 64'd5, 5'd14, 8'h02, 1'b0, 2, 64'd2, 1'b1, ho); wait_done();
        // Non-divide funct3: accepted, never launched, returns zero
        issue(3'd0, 1'b0, 64'd9, 64'd9, 5'd15, 8'h00, 1'b0, 1, 64'd0, 1'b1, ho); wait_done();

        // Flush ten cycles into WAIT: drain silently
        issue(3'd4, 1'b0, 64'd1000, 64'd10, 5'd9, 8'h80, 1'b0, 20, 64'd100, 1'b0, ho);
        acc = cyc;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        ok_seen = 1'b0;
        for (int i = 0; i < 40 && !ok_seen; i++) begin
            @(negedge clk);
            chk("drain_div_rready", div_rready, 1'b1);
            chk("drain_out_valid", out_valid, 1'b0);
            chk("drain_in_ready", in_ready, 1'b0);
            chk("drain_busy", busy, 1'b1);
            if (div_ok) ok_seen = 1'b1;
        end
        chk("drain_div_ok_seen", ok_seen, 1'b1);
        @(negedge clk);
        chk("after_drain_busy", busy, 1'b0);
        chk("after_drain_in_ready", in_ready, 1'b1);
        $display("flush drained, flushed op accepted near cycle %0d", acc);
        @(posedge clk); #1;
        issue(3'd5, 1'b0, 64'd63, 64'd8, 5'd20, 8'h40, 1'b0, 3, 64'd7, 1'b1, ho); wait_done();

        // Hold response with out_ready low, then hand off into a new op in the same cycle
        out_ready = 1'b0;
        issue(3'd5, 1'b0, 64'd100, 64'd7, 5'd4, 8'h40, 1'b0, 3, 64'd14, 1'b1, ho);
        ok_seen = 1'b0;
        for (int i = 0; i < 50 && !ok_seen; i++) begin
            @(negedge clk);
            if (out_valid) ok_seen = 1'b1;
        end
        chk("hold_out_valid_seen", ok_seen, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1'b1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(3'd7, 1'b0, 64'd50, 64'd6, 5'd5, 8'h04, 1'b0, 2, 64'd2, 1'b1, ho);
        chk("handoff_same_cycle", ho, 1'b1);
        wait_done();

        // Reset while in WAIT
        issue(3'd4, 1'b0, 64'd5000, 64'd3, 5'd6, 8'h80, 1'b0, 30, 64'd1666, 1'b0, ho);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("wait_rst_busy", busy, 1'b0);
        chk("wait_rst_in_ready", in_ready, 1'b1);
        chk("wait_rst_div_rready", div_rready, 1'b0);
        @(posedge clk); #1;
        issue(3'd6, 1'b0, 64'd50, 64'd6, 5'd8, 8'h08, 1'b0, 2, 64'd2, 1'b1, ho); wait_done();

        chk("launch_q_empty", launch_q.size(), 64'd0);
        chk("out_q_empty", out_q.size(), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
